// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the two-port alu arbiter and its alu.
package alu_share_arbiter_pkg;

  localparam int ALU_W = 32;

  // Gselect codes. Arithmetic codes are A + Y + cin, where {Y sel, cin} = op[2:0].
  // Logic codes ignore op[0].
  localparam logic [3:0] TRANSFER_A  = 4'b0000;
  localparam logic [3:0] INC_A       = 4'b0001;
  localparam logic [3:0] ADD_AB      = 4'b0010;
  localparam logic [3:0] ADD_AB_C    = 4'b0011;
  localparam logic [3:0] A_PLUS_NB   = 4'b0100;
  localparam logic [3:0] SUB_AB      = 4'b0101;
  localparam logic [3:0] DEC_A       = 4'b0110;
  localparam logic [3:0] TRANSFER_A1 = 4'b0111;
  localparam logic [3:0] AND_AB      = 4'b1000;
  localparam logic [3:0] OR_AB       = 4'b1010;
  localparam logic [3:0] XOR_AB      = 4'b1100;
  localparam logic [3:0] NOT_A       = 4'b1110;

  // Requester indices.
  localparam logic P_EX = 1'b0;
  localparam logic P_BR = 1'b1;

  // Output register occupancy.
  typedef enum logic {ST_EMPTY, ST_FULL} obuf_state_e;

  // Registered response payload.
  typedef struct packed {
    logic [ALU_W-1:0] g;
    logic             c;
    logic             v;
    logic             err;
  } rsp_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// 32-bit alu: G = f(A, B, Gselect) with carry-out and signed overflow.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  output logic [W-1:0] g,
  output logic         c,
  output logic         v
);

  logic [W-1:0] y;
  logic [W:0]   sum;

  // Arithmetic path: pick Y from {0, B, ~B, all-ones}, add with cin = sel[0].
  always_comb begin
    y = '0;
    unique case (sel[2:1])
      2'b00: y = '0;
      2'b01: y = b;
      2'b10: y = ~b;
      default: y = '1;
    endcase
    sum = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, sel[0]};
  end

  // Result select; logic ops report no carry or overflow.
  always_comb begin
    g = sum[W-1:0];
    c = sum[W];
    v = (a[W-1] == y[W-1]) && (sum[W-1] != a[W-1]);
    if (sel[3]) begin
      c = 1'b0;
      v = 1'b0;
      unique case (sel[3:1])
        AND_AB[3:1]: g = a & b;
        OR_AB[3:1]:  g = a | b;
        XOR_AB[3:1]: g = a ^ b;
        default:     g = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu between EX (port 0) and branch/address (port 1).
// One registered response slot; drain and accept may overlap for 1 op/cycle.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic        RR_INIT  = 1'b1,
  parameter logic [15:0] OP_MASK1 = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [3:0]        req_op0,
  input  logic [3:0]        req_op1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_g,
  output logic              rsp_c,
  output logic              rsp_v,
  output logic              rsp_err,
  output logic              busy
);

  obuf_state_e       state;
  logic              owner;
  logic              last_grant;
  rsp_t              rsp_q;

  logic              drain;
  logic              can_accept;
  logic              grant;
  logic              accept;
  logic              illegal;
  logic [DATA_W-1:0] alu_a, alu_b, alu_g;
  logic [3:0]        alu_op;
  logic              alu_c, alu_v;

  // Slot frees this cycle only when its owner takes the response.
  assign drain      = (state == ST_FULL) && rsp_ready[owner];
  // Gating with rst_n keeps ready low for the whole reset window.
  assign can_accept = rst_n && ((state == ST_EMPTY) || drain);

  // Lone requester wins; on contention the port that did not win last time.
  always_comb begin
    grant = P_EX;
    unique case (req_valid)
      2'b10:   grant = P_BR;
      2'b11:   grant = ~last_grant;
      default: grant = P_EX;
    endcase
  end

  assign accept    = can_accept && (req_valid != 2'b00);
  assign req_ready = !accept ? 2'b00 : (grant ? 2'b10 : 2'b01);

  assign alu_a   = grant ? req_a1  : req_a0;
  assign alu_b   = grant ? req_b1  : req_b0;
  assign alu_op  = grant ? req_op1 : req_op0;
  // Only the branch port is restricted; EX may issue any code.
  assign illegal = (grant == P_BR) && !OP_MASK1[alu_op];

  alu_share_arbiter_alu #(.W(DATA_W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_op),
    .g   (alu_g),
    .c   (alu_c),
    .v   (alu_v)
  );

  // Output slot FSM, round-robin pointer and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      owner      <= P_EX;
      last_grant <= RR_INIT;
      rsp_q      <= '0;
    end else if (accept) begin
      state      <= ST_FULL;
      owner      <= grant;
      last_grant <= grant;
      if (illegal) rsp_q <= '{g: '0, c: 1'b0, v: 1'b0, err: 1'b1};
      else         rsp_q <= '{g: alu_g, c: alu_c, v: alu_v, err: 1'b0};
    end else if (drain) begin
      state <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state != ST_FULL) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign rsp_g     = rsp_q.g;
  assign rsp_c     = rsp_q.c;
  assign rsp_v     = rsp_q.v;
  assign rsp_err   = rsp_q.err;
  assign busy      = (state == ST_FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle model predicts ready/valid,
// expected results are queued at accept and compared while the response is held.
module tb_alu_share_arbiter;

  localparam logic [15:0] MASK1 = 16'h00FF;
  localparam logic        RR    = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [3:0]  req_op0 = '0, req_op1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_g;
  logic        rsp_c, rsp_v, rsp_err, busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .RR_INIT(RR), .OP_MASK1(MASK1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_g(rsp_g), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct packed {
    logic        err;
    logic        v;
    logic        c;
    logic [31:0] g;
  } exp_t;

  exp_t sb_q[$];
  logic gnt_log[$];
  int   n_run = 0;
  int   n_fail = 0;
  logic m_full, m_owner, m_last;
  logic [1:0] taken = 2'b00;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference alu written as a per-code table of A + Y + cin.
  function automatic exp_t model(logic p, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] y;
    logic        ci;
    logic [32:0] s;
    exp_t        r;
    r = '0;
    if (p && !MASK1[op]) begin
      r.err = 1'b1;
      return r;
    end
    if (op[3]) begin
      case (op)
        4'd8, 4'd9:   r.g = a & b;
        4'd10, 4'd11: r.g = a | b;
        4'd12, 4'd13: r.g = a ^ b;
        default:      r.g = ~a;
      endcase
      return r;
    end
    case (op)
      4'd0:    begin y = 32'h0;        ci = 1'b0; end
      4'd1:    begin y = 32'h0;        ci = 1'b1; end
      4'd2:    begin y = b;            ci = 1'b0; end
      4'd3:    begin y = b;            ci = 1'b1; end
      4'd4:    begin y = ~b;           ci = 1'b0; end
      4'd5:    begin y = ~b;           ci = 1'b1; end
      4'd6:    begin y = 32'hFFFFFFFF; ci = 1'b0; end
      default: begin y = 32'hFFFFFFFF; ci = 1'b1; end
    endcase
    s   = {1'b0, a} + {1'b0, y} + {32'b0, ci};
    r.g = s[31:0];
    r.c = s[32];
    r.v = (a[31] == y[31]) && (s[31] != a[31]);
    return r;
  endfunction

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Cycle model, evaluated mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_out", {rsp_valid, busy, rsp_err, rsp_c, rsp_v, rsp_g}, '0);
      m_full = 1'b0;
      m_owner = 1'b0;
      m_last = RR;
      taken = 2'b00;
      sb_q.delete();
    end else begin
      logic       drn, can, gnt;
      logic [1:0] exp_rdy;
      exp_t       e;
      chk("rsp_valid", rsp_valid, m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      chk("busy", busy, m_full);
      if (m_full) begin
        if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
        else chk("rsp_data", {rsp_err, rsp_v, rsp_c, rsp_g}, sb_q[0]);
      end
      drn = m_full && rsp_ready[m_owner];
      can = !m_full || drn;
      gnt = (req_valid == 2'b11) ? ~m_last : req_valid[1] & ~req_valid[0];
      exp_rdy = (can && req_valid != 2'b00) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, exp_rdy);
      taken = req_valid & req_ready;
      if (drn && sb_q.size() != 0) void'(sb_q.pop_front());
      if (exp_rdy != 2'b00) begin
        e = gnt ? model(1'b1, req_a1, req_b1, req_op1) : model(1'b0, req_a0, req_b0, req_op0);
        sb_q.push_back(e);
        gnt_log.push_back(gnt);
        m_full = 1'b1;
        m_owner = gnt;
        m_last = gnt;
      end else if (drn) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_take(logic p);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (taken[p]) begin
        #1;
        req_valid[p] = 1'b0;
        return;
      end
    end
    chk("take_timeout", taken[p], 1);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic send(logic p, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    if (p) begin req_a1 = a; req_b1 = b; req_op1 = op; end
    else   begin req_a0 = a; req_b0 = b; req_op0 = op; end
    req_valid[p] = 1'b1;
    wait_take(p);
  endtask

  task automatic new_ops(int p);
    if (p == 1) begin req_a1 = rword(); req_b1 = rword(); req_op1 = 4'($urandom_range(0, 15)); end
    else        begin req_a0 = rword(); req_b0 = rword(); req_op0 = 4'($urandom_range(0, 15)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: requests held during reset are not accepted; clean outputs after release.
    req_valid = 2'b11;
    tick(); tick();
    chk("t1_ready_in_rst", req_ready, 2'b00);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
    chk("t1_idle", {rsp_valid, busy, rsp_err, rsp_c, rsp_v, rsp_g}, '0);

    // 2: increment of all-ones wraps to zero with carry, one edge latency.
    rsp_ready = 2'b11;
    send(1'b0, 32'hFFFFFFFF, 32'h0, 4'b0001);
    chk("t2_valid", rsp_valid, 2'b01);
    chk("t2_gce", {rsp_err, rsp_c, rsp_g}, {1'b0, 1'b1, 32'h0});
    tick();

    // 4: branch response held three cycles while EX waits.
    rsp_ready = 2'b00;
    send(1'b1, 32'h12345678, 32'h11111111, 4'b0010);
    req_a0 = 32'hA5A5A5A5; req_b0 = 32'h5A5A5A5A; req_op0 = 4'b1010;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_ready", req_ready, 2'b00);
      chk("t4_hold_data", {rsp_valid, rsp_err, rsp_g}, {2'b10, 1'b0, 32'h23456789});
      tick();
    end
    rsp_ready = 2'b11;
    wait_take(1'b0);
    chk("t4_next", {rsp_valid, rsp_g}, {2'b01, 32'hFFFFFFFF});

    // 5: masked code on port 1 errors; same code on port 0 computes AND.
    send(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 4'b1000);
    chk("t5_br_valid", rsp_valid, 2'b10);
    chk("t5_br_err", {rsp_err, rsp_c, rsp_v, rsp_g}, {1'b1, 1'b0, 1'b0, 32'h0});
    send(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b1000);
    chk("t5_ex_valid", rsp_valid, 2'b01);
    chk("t5_ex_and", {rsp_err, rsp_g}, {1'b0, 32'hF000F000});
    tick();

    // 3: full contention from reset alternates 0,1,0,1 at one op per cycle.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    gnt_log.delete();
    new_ops(0); new_ops(1);
    req_valid = 2'b11;
    repeat (8) begin
      tick();
      for (int p = 0; p < 2; p++) if (taken[p]) new_ops(p);
    end
    req_valid = 2'b00;
    chk("t3_count", gnt_log.size(), 8);
    for (int k = 0; k < 4; k++) chk("t3_grant", gnt_log[k], k % 2);
    tick(); tick();

    // 6: reset while FULL (last winner port 0) clears at once; first contention goes to port 0.
    rsp_ready = 2'b00;
    send(1'b0, 32'h00000005, 32'h00000003, 4'b0101);
    chk("t6_full", {rsp_valid, busy}, {2'b01, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("t6_async", {rsp_valid, busy, rsp_err, rsp_c, rsp_v, rsp_g}, '0);
    tick();
    rst_n = 1'b1;
    gnt_log.delete();
    rsp_ready = 2'b11;
    new_ops(0); new_ops(1);
    req_valid = 2'b11;
    tick();
    chk("t6_first_cnt", gnt_log.size(), 1);
    chk("t6_first_grant", gnt_log[0], 0);

    // Random traffic with random backpressure.
    repeat (400) begin
      tick();
      rsp_ready = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] || taken[p]) begin
          req_valid[p] = 1'($urandom_range(0, 1));
          new_ops(p);
        end
      end
    end

    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
